// File: rtl/pacman_sprite_anim.sv
// Animated Pac-Man sprite: mouth-frame sequencing with tick-aligned direction changes
// and a registered single-bit pixel lookup from a mirrored right/down frame ROM.
module pacman_sprite_anim #(
  parameter int SPRITE_W   = 16,
  parameter int SPRITE_H   = 16,
  parameter int NUM_FRAMES = 3,
  parameter int FRAME_DIV  = 8,
  parameter int PINGPONG   = 1,
  localparam int RW = $clog2(SPRITE_H),
  localparam int CW = $clog2(SPRITE_W),
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          frame_tick,
  input  logic          moving,
  input  logic [1:0]    dir_in,
  input  logic          dir_valid,
  input  logic          pix_req,
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  output logic          pix_on,
  output logic          pix_valid,
  output logic [1:0]    cur_dir,
  output logic [FW-1:0] cur_frame
);

  localparam logic [1:0] DIR_DOWN  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam int DW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int DEPTH = 2 * NUM_FRAMES * SPRITE_H;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Closed disc minus a per-frame mouth mask; mouth faces right (LSB side) or down (bottom rows).
  function automatic logic [15:0] sprite_row(input int base, input int frame, input int r);
    logic [15:0] disc;
    logic [15:0] mask;
    case (r)
      2, 13:         disc = 16'h03C0;
      3, 12:         disc = 16'h07E0;
      4, 11:         disc = 16'h0FF0;
      5, 10:         disc = 16'h1FF8;
      6, 7, 8, 9:    disc = 16'h3FFC;
      default:       disc = 16'h0000;
    endcase
    mask = 16'h0000;
    if (frame == 0) begin
      if (base == 1) begin
        case (r)
          6, 9:    mask = 16'h001C;
          7, 8:    mask = 16'h003C;
          default: mask = 16'h0000;
        endcase
      end else begin
        case (r)
          10:         mask = 16'h0180;
          11, 12, 13: mask = 16'h03C0;
          default:    mask = 16'h0000;
        endcase
      end
    end else if (frame != NUM_FRAMES - 1) begin
      if (base == 1) begin
        case (r)
          7, 8:    mask = 16'h001C;
          default: mask = 16'h0000;
        endcase
      end else begin
        case (r)
          12:      mask = 16'h0180;
          13:      mask = 16'h03C0;
          default: mask = 16'h0000;
        endcase
      end
    end
    return disc & ~mask;
  endfunction

  logic [SPRITE_W-1:0] rom [DEPTH];

  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    assign rom[a] = SPRITE_W'(sprite_row(a / (NUM_FRAMES * SPRITE_H),
                                         (a / SPRITE_H) % NUM_FRAMES,
                                         a % SPRITE_H));
  end

  logic [1:0]    dir_q, dir_d;
  logic [1:0]    pend_q, pend_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [DW-1:0] div_q, div_d;
  logic          pp_down_q, pp_down_d;
  logic          pix_on_q, pix_on_d;
  logic          pix_valid_q, pix_valid_d;
  logic          step;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dir_q       <= DIR_RIGHT;
      pend_q      <= DIR_RIGHT;
      frame_q     <= '0;
      div_q       <= '0;
      pp_down_q   <= 1'b0;
      pix_on_q    <= 1'b0;
      pix_valid_q <= 1'b0;
    end else begin
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      frame_q     <= frame_d;
      div_q       <= div_d;
      pp_down_q   <= pp_down_d;
      pix_on_q    <= pix_on_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  // A direction written in the same cycle as the tick bypasses the pending register.
  always_comb begin
    pend_d = pend_q;
    dir_d  = dir_q;
    if (dir_valid) pend_d = dir_in;
    if (frame_tick) dir_d = dir_valid ? dir_in : pend_q;
  end

  always_comb begin
    div_d     = div_q;
    frame_d   = frame_q;
    pp_down_d = pp_down_q;
    step      = 1'b0;
    if (frame_tick && moving) begin
      if (div_q == DW'(FRAME_DIV - 1)) begin
        div_d = '0;
        step  = 1'b1;
      end else begin
        div_d = div_q + DW'(1);
      end
    end
    if (step && (NUM_FRAMES > 1)) begin
      if (PINGPONG == 0) begin
        frame_d = (frame_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_q + FW'(1);
      end else if (!pp_down_q) begin
        frame_d = frame_q + FW'(1);
        if (frame_q == FW'(NUM_FRAMES - 2)) pp_down_d = 1'b1;
      end else begin
        frame_d = frame_q - FW'(1);
        if (frame_q == FW'(1)) pp_down_d = 1'b0;
      end
    end
  end

  // Power-of-two sizes make H-1-row and W-1-col plain inversions; bit c counts from the MSB.
  logic [RW-1:0]       r_idx;
  logic [CW-1:0]       c_idx;
  logic [AW-1:0]       rom_addr;
  logic [SPRITE_W-1:0] rom_word;

  always_comb begin
    r_idx       = (dir_q == DIR_UP)   ? ~row : row;
    c_idx       = (dir_q == DIR_LEFT) ? ~col : col;
    rom_addr    = AW'((int'(dir_q[1]) * NUM_FRAMES + int'(frame_q)) * SPRITE_H + int'(r_idx));
    rom_word    = rom[rom_addr];
    pix_valid_d = pix_req;
    pix_on_d    = pix_req & rom_word[~c_idx];
  end

  assign pix_on    = pix_on_q;
  assign pix_valid = pix_valid_q;
  assign cur_dir   = dir_q;
  assign cur_frame = frame_q;

endmodule
